servo_pwm_multi: RTL and testbench

- Parametrised N-channel hobby-servo PWM generator; successor to the single-channel key-driven angle-to-PWM path.
- Accepts angle commands per channel over a valid/ready port and clamps them to MAX_ANGLE.
- Commits new angles only at 20 ms frame boundaries, so no pulse is ever truncated.
- Optionally slew-limits each channel's angle. Sits between the key/command decoder and the servo output pins.

---
 rtl/servo_pkg.sv | 35 +++
 rtl/servo_pwm_chan.sv | 97 +++++++++
 rtl/servo_pwm_multi.sv | 122 ++++++++++++
 tb/tb_servo_pwm_multi.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, angle type and helper functions for the multi-channel servo PWM block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The frame/pulse constants here are the default values for the top-level
// parameters; instances may override them. The optional slew feature is
// selected with the SERVO_SLEW_EN macro (see servo_pwm_chan).
package servo_pkg;

  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned ANGLE_W       = 9;
  localparam int unsigned MAX_ANGLE     = 270;
  localparam int unsigned RESET_ANGLE   = 135;
  localparam int unsigned PERIOD_CYC    = 1000000;  // 20 ms at 50 MHz
  localparam int unsigned MIN_PULSE_CYC = 25000;    // 0.5 ms high time at angle 0
  localparam int unsigned TICKS_PER_DEG = 370;
  localparam int unsigned SLEW_STEP     = 5;

  typedef logic [ANGLE_W-1:0] angle_t;

  // Saturate a requested angle to the largest legal angle.
  function automatic int unsigned clamp_angle(input int unsigned angle,
                                              input int unsigned max_angle);
    return (angle > max_angle) ? max_angle : angle;
  endfunction

  // High time in clock cycles for a given angle. Evaluated in 32-bit
  // arithmetic so it can be used for elaboration-time range checks.
  function automatic int unsigned pulse_cyc(input int unsigned angle,
                                            input int unsigned min_pulse,
                                            input int unsigned ticks_per_deg);
    return min_pulse + angle * ticks_per_deg;
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: target/active angle registers, optional slew limiter, pulse comparator.
// Latency: target written 1 cycle after accept; active follows target only at the frame boundary.
// Backpressure: none; a write is taken whenever wr_en is high.
//
// Ports:
//   sclk, rst  - clock, asynchronous active-high reset
//   cnt_nxt    - frame count the shared counter will hold next cycle
//   boundary   - high in the last cycle of a frame (count == PERIOD_CYC-1)
//   wr_en      - write wr_angle (already clamped) into the target register
//   busy       - registered: active angle differs from target angle
//   pwm        - registered servo pulse, aligned with the shared count
//
// Build option: `define SERVO_SLEW_EN to limit the per-frame change of the
// active angle to SLEW_STEP degrees; otherwise active jumps to target.
module servo_pwm_chan
#(
  parameter int unsigned ANGLE_W       = 9,
  parameter int unsigned RESET_ANGLE   = 135,
  parameter int unsigned MIN_PULSE_CYC = 25000,
  parameter int unsigned TICKS_PER_DEG = 370,
`ifdef SERVO_SLEW_EN
  parameter int unsigned SLEW_STEP     = 5,
`endif
  parameter int unsigned CNT_W         = 20
)
(
  input  logic               sclk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cnt_nxt,
  input  logic               boundary,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_angle,
  output logic               busy,
  output logic               pwm
);

  logic [ANGLE_W-1:0] target;
  logic [ANGLE_W-1:0] active;
  logic [ANGLE_W-1:0] tgt_nxt;
  logic [ANGLE_W-1:0] act_nxt;
  logic [ANGLE_W-1:0] act_step;   // value active takes at the next boundary
  logic [CNT_W-1:0]   thr;

  assign tgt_nxt = wr_en ? wr_angle : target;

`ifdef SERVO_SLEW_EN
  localparam int unsigned AW1 = ANGLE_W + 1;

  // Differences and candidate steps are one bit wider than an angle so the
  // comparisons never wrap; a downward step is only taken when the distance
  // exceeds SLEW_STEP, so active - SLEW_STEP stays above target (>= 0).
  logic [AW1-1:0] diff_up;
  logic [AW1-1:0] diff_dn;
  logic [AW1-1:0] step_up;
  logic [AW1-1:0] step_dn;

  always_comb begin
    diff_up  = {1'b0, target} - {1'b0, active};
    diff_dn  = {1'b0, active} - {1'b0, target};
    step_up  = {1'b0, active} + AW1'(SLEW_STEP);
    step_dn  = {1'b0, active} - AW1'(SLEW_STEP);
    act_step = target;
    if (target > active) begin
      if (diff_up > AW1'(SLEW_STEP)) begin
        act_step = step_up[ANGLE_W-1:0];
      end
    end else if (diff_dn > AW1'(SLEW_STEP)) begin
      act_step = step_dn[ANGLE_W-1:0];
    end
  end
`else
  assign act_step = target;
`endif

  // The boundary uses the target as it stands before any write landing in
  // the same cycle, so a command on the boundary waits one more frame.
  assign act_nxt = boundary ? act_step : active;

  // Comparing against next-cycle count and angle keeps the registered pulse
  // aligned with the count: the new angle governs the pulse from count 0.
  assign thr = CNT_W'(MIN_PULSE_CYC) + CNT_W'(act_nxt) * CNT_W'(TICKS_PER_DEG);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      target <= ANGLE_W'(RESET_ANGLE);
      active <= ANGLE_W'(RESET_ANGLE);
      busy   <= 1'b0;
      pwm    <= 1'b0;
    end else begin
      target <= tgt_nxt;
      active <= act_nxt;
      busy   <= (act_nxt != tgt_nxt);
      pwm    <= (cnt_nxt < thr);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM generator; angle commands commit only at 20 ms frame boundaries.
// Latency: command -> target 1 cycle; target -> pulse at the next frame start.
// Backpressure: cmd_ready is low only during reset and the first cycle after it; never stalls after that.
//
// Ports:
//   sclk, rst    - clock, asynchronous active-high reset
//   cmd_valid    - command present; accepted when cmd_ready is also high
//   cmd_ready    - block can accept a command
//   cmd_chan     - target channel; indices >= NUM_CH are accepted and dropped
//   cmd_angle    - requested angle in degrees, clamped to MAX_ANGLE
//   frame_start  - high during the cycle in which the frame count is 0
//   busy         - per channel: active angle != target angle
//   PWM          - per channel servo pulse
//
// Build option: `define SERVO_SLEW_EN to slew-limit each channel by
// SLEW_STEP degrees per frame; without it SLEW_STEP is ignored.
module servo_pwm_multi
#(
  parameter int unsigned NUM_CH        = servo_pkg::NUM_CH,
  parameter int unsigned ANGLE_W       = servo_pkg::ANGLE_W,
  parameter int unsigned MAX_ANGLE     = servo_pkg::MAX_ANGLE,
  parameter int unsigned RESET_ANGLE   = servo_pkg::RESET_ANGLE,
  parameter int unsigned PERIOD_CYC    = servo_pkg::PERIOD_CYC,
  parameter int unsigned MIN_PULSE_CYC = servo_pkg::MIN_PULSE_CYC,
  parameter int unsigned TICKS_PER_DEG = servo_pkg::TICKS_PER_DEG,
  parameter int unsigned SLEW_STEP     = servo_pkg::SLEW_STEP,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
  input  logic               sclk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CH_W-1:0]    cmd_chan,
  input  logic [ANGLE_W-1:0] cmd_angle,
  output logic               frame_start,
  output logic [NUM_CH-1:0]  busy,
  output logic [NUM_CH-1:0]  PWM
);

  import servo_pkg::*;

  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);

  // ---------------------------------------------------------------- checks
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("servo_pwm_multi: NUM_CH must be 1..16");
  end
  if (MAX_ANGLE >= (1 << ANGLE_W)) begin : g_bad_angle_w
    $error("servo_pwm_multi: MAX_ANGLE does not fit in ANGLE_W bits");
  end
  if (RESET_ANGLE > MAX_ANGLE) begin : g_bad_reset_angle
    $error("servo_pwm_multi: RESET_ANGLE exceeds MAX_ANGLE");
  end
  if (pulse_cyc(MAX_ANGLE, MIN_PULSE_CYC, TICKS_PER_DEG) >= PERIOD_CYC) begin : g_bad_pulse
    $error("servo_pwm_multi: widest pulse does not fit inside one frame");
  end
  if (SLEW_STEP > MAX_ANGLE) begin : g_bad_slew
    $error("servo_pwm_multi: SLEW_STEP exceeds MAX_ANGLE");
  end

  // ---------------------------------------------------------- frame timing
  logic               run;        // low in reset and for the first cycle after it
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               boundary;
  logic               accept;
  logic [ANGLE_W-1:0] cmd_angle_c;

  assign boundary = run && (cnt == CNT_W'(PERIOD_CYC - 1));

  // The counter idles at 0 until run is set, so the first frame after reset
  // begins exactly one cycle after release, together with frame_start.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (!run || boundary) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      cnt         <= cnt_nxt;
      frame_start <= (cnt_nxt == '0);
    end
  end

  // ------------------------------------------------------------- commands
  assign cmd_ready   = run;
  assign accept      = cmd_valid && cmd_ready;
  assign cmd_angle_c = ANGLE_W'(clamp_angle(32'(cmd_angle), MAX_ANGLE));

  // ------------------------------------------------------------- channels
  // An out-of-range cmd_chan matches no channel, so the command is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_chan #(
      .ANGLE_W       (ANGLE_W),
      .RESET_ANGLE   (RESET_ANGLE),
      .MIN_PULSE_CYC (MIN_PULSE_CYC),
      .TICKS_PER_DEG (TICKS_PER_DEG),
`ifdef SERVO_SLEW_EN
      .SLEW_STEP     (SLEW_STEP),
`endif
      .CNT_W         (CNT_W)
    ) u_chan (
      .sclk     (sclk),
      .rst      (rst),
      .cnt_nxt  (cnt_nxt),
      .boundary (boundary),
      .wr_en    (accept && (cmd_chan == CH_W'(i))),
      .wr_angle (cmd_angle_c),
      .busy     (busy[i]),
      .pwm      (PWM[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi with a shortened frame so many frames fit in a short run.
// Frame 1000 cycles, high time 25 + 3*angle: 135 -> 430, 270 -> 835, 90 -> 295, 0 -> 25.
// Five channels so the 3-bit channel field can carry the out-of-range index 7.
module tb_servo_pwm_multi;

  localparam int unsigned NCH  = 5;
  localparam int unsigned P    = 1000;
  localparam int unsigned MINP = 25;
  localparam int unsigned TK   = 3;

  logic           sclk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_chan = '0;
  logic [8:0]     cmd_angle = '0;
  logic           cmd_ready;
  logic           frame_start;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] pwm;

  servo_pwm_multi #(
    .NUM_CH        (NCH),
    .ANGLE_W       (9),
    .MAX_ANGLE     (270),
    .RESET_ANGLE   (135),
    .PERIOD_CYC    (P),
    .MIN_PULSE_CYC (MINP),
    .TICKS_PER_DEG (TK),
    .SLEW_STEP     (5)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_chan    (cmd_chan),
    .cmd_angle   (cmd_angle),
    .frame_start (frame_start),
    .busy        (busy),
    .PWM         (pwm)
  );

  always #5 sclk = ~sclk;

  // Expected result for one whole frame: per-channel high time, busy sampled
  // in the first cycle of the frame and in the last cycle of the frame.
  typedef struct packed {
    logic [NCH-1:0][11:0] hi;
    logic [NCH-1:0]       bs;
    logic [NCH-1:0]       be;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pos;            // stimulus view of the frame count (sampled at negedge)
  logic [NCH-1:0] pwm_mid;

  function automatic exp_t mk(input int h0, input int h1, input int h2, input int h3,
                              input int h4, input logic [NCH-1:0] bs,
                              input logic [NCH-1:0] be);
    exp_t e;
    e.hi[0] = 12'(h0);
    e.hi[1] = 12'(h1);
    e.hi[2] = 12'(h2);
    e.hi[3] = 12'(h3);
    e.hi[4] = 12'(h4);
    e.bs    = bs;
    e.be    = be;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
    pos++;
  endtask

  task automatic goto(input int k);
    while (pos < k) tick();
  endtask

  task automatic send_at(input int k, input int ch, input int ang);
    goto(k);
    cmd_valid = 1'b1;
    cmd_chan  = 3'(ch);
    cmd_angle = 9'(ang);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Expectations are queued in the last cycle of the previous frame, so the
  // monitor always finds them when the frame it describes begins.
  task automatic expect_next(input exp_t e);
    goto(P - 1);
    q.push_back(e);
  endtask

  task automatic next_frame();
    goto(P);
    pos = 0;
  endtask

  task automatic release_rst();
    @(negedge sclk);
    rst = 1'b0;
    #1;
    chk("frame_start right after release", 32'(frame_start), 0);
    chk("cmd_ready right after release", 32'(cmd_ready), 0);
    @(negedge sclk);
    chk("frame_start one cycle after release", 32'(frame_start), 1);
    chk("cmd_ready one cycle after release", 32'(cmd_ready), 1);
    pos = 0;
  endtask

  // ------------------------------------------------------------- monitor
  initial begin : monitor
    int             hi[NCH];
    logic [NCH-1:0] bs;
    logic [NCH-1:0] be;
    exp_t           e;
    int             n;
    bit             prev;
    prev = 1'b0;
    forever begin
      n = 0;
      @(negedge sclk);
      while (frame_start !== 1'b1 && n < 3 * P) begin
        @(negedge sclk);
        n++;
      end
      if (frame_start !== 1'b1) begin
        chk("frame_start timeout", 0, 1);
        prev = 1'b0;
        continue;
      end
      if (prev) chk("frame period", 32'(n), 0);
      if (q.size() == 0) begin
        prev = 1'b0;
        continue;
      end
      e = q.pop_front();
      for (int i = 0; i < NCH; i++) hi[i] = 0;
      bs = busy;
      be = '0;
      chk("cmd_ready at frame start", 32'(cmd_ready), 1);
      for (int c = 0; c < P; c++) begin
        if (c > 0) @(negedge sclk);
        for (int i = 0; i < NCH; i++) hi[i] += int'(pwm[i]);
        if (c == P - 1) be = busy;
      end
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("ch%0d high time", i), 32'(hi[i]), 32'(e.hi[i]));
      end
      chk("busy at frame start", 32'(bs), 32'(e.bs));
      chk("busy at frame end", 32'(be), 32'(e.be));
      prev = 1'b1;
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin : stim
    pos = 0;
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    chk("reset PWM", 32'(pwm), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset frame_start", 32'(frame_start), 0);
    chk("reset cmd_ready", 32'(cmd_ready), 0);

    q.push_back(mk(430, 430, 430, 430, 430, 5'b00000, 5'b00000));
    release_rst();

`ifdef SERVO_SLEW_EN
    // Frame 0: idle. Frame 1: ch1 -> 0 during the pulse, then ramp by 5 deg/frame.
    expect_next(mk(430, 430, 430, 430, 430, 5'b00000, 5'b00010));
    next_frame();
    send_at(200, 1, 0);
    for (int k = 1; k <= 27; k++) begin
      expect_next(mk(430, 430 - 15 * k, 430, 430, 430,
                     (k < 27) ? 5'b00010 : 5'b00000,
                     (k < 27) ? 5'b00010 : 5'b00000));
      next_frame();
    end
    pwm_mid = 5'b11101;
`else
    // Frame 0: idle.
    expect_next(mk(430, 430, 430, 430, 430, 5'b00000, 5'b00100));
    next_frame();
    // Frame 1: ch2 -> 270 while its pulse is high; current pulse untouched.
    send_at(200, 2, 270);
    expect_next(mk(430, 430, 835, 430, 430, 5'b00000, 5'b00001));
    next_frame();
    // Frame 2: ch0 -> 400, clamped to 270.
    send_at(200, 0, 400);
    expect_next(mk(835, 430, 835, 430, 430, 5'b00000, 5'b00000));
    next_frame();
    // Frame 3: ch3 -> 0 in the boundary cycle; takes effect one frame later.
    expect_next(mk(835, 430, 835, 430, 430, 5'b01000, 5'b01000));
    send_at(P - 1, 3, 0);
    next_frame();
    // Frame 4: ch3 still at 135, busy until the next boundary.
    expect_next(mk(835, 430, 835, 25, 430, 5'b00000, 5'b10000));
    next_frame();
    // Frame 5: out-of-range chan 7 dropped; back-to-back ch4 writes, last wins.
    send_at(100, 7, 200);
    send_at(300, 4, 10);
    send_at(301, 4, 90);
    expect_next(mk(835, 430, 835, 25, 295, 5'b00000, 5'b00000));
    next_frame();
    pwm_mid = 5'b10111;
`endif

    // Reset in the middle of a pulse of a frame that is not scored.
    next_frame();
    goto(100);
    chk("PWM before mid-pulse reset", 32'(pwm), 32'(pwm_mid));
    rst = 1'b1;
    #1;
    chk("PWM after async reset", 32'(pwm), 0);
    chk("busy after async reset", 32'(busy), 0);
    chk("cmd_ready after async reset", 32'(cmd_ready), 0);
    chk("frame_start after async reset", 32'(frame_start), 0);
    repeat (3) @(negedge sclk);
    q.push_back(mk(430, 430, 430, 430, 430, 5'b00000, 5'b00000));
    release_rst();
    next_frame();

    chk("scoreboard drained", 32'(q.size()), 0);
    repeat (2) @(negedge sclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
